ex_muldiv: RTL and testbench



---
 rtl/ex_muldiv.sv | 125 ++++++++++++
 tb/tb_ex_muldiv.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO for the EX stage.
// Define MULDIV_FAST_MULT_EN to compute multiplies in one cycle with a combinational multiplier.
module ex_muldiv (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        abort,
   input  logic        mthi_en,
   input  logic        mtlo_en,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;
   logic        div_q, div_d, neg_q, neg_d, sa_q, sa_d, dz_q, dz_d, done_q, done_d;
   logic        sa, sb, ge;
   logic [31:0] abs_a, abs_b, rsub, quo, rem;
   logic [32:0] msum, sh;
   logic [63:0] step, prod;
`ifdef MULDIV_FAST_MULT_EN
   logic [63:0] fprod;
`endif
   // acc holds {upper, lower} for multiply and {remainder, dividend/quotient} for divide
   always_comb begin
      sa    = ~op[0] & a[31];
      sb    = ~op[0] & b[31];
      abs_a = sa ? -a : a;
      abs_b = sb ? -b : b;
      msum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
      sh    = acc_q[63:31];
      ge    = sh >= {1'b0, m_q};
      rsub  = sh[31:0] - m_q;
      step  = div_q ? {ge ? rsub : sh[31:0], acc_q[30:0], ge} : {msum, acc_q[31:1]};
      prod  = neg_q ? -acc_q : acc_q;
      quo   = dz_q ? 32'hFFFF_FFFF : neg_q ? -acc_q[31:0] : acc_q[31:0];
      rem   = sa_q ? -acc_q[63:32] : acc_q[63:32];
`ifdef MULDIV_FAST_MULT_EN
      fprod = 64'($signed({sa, a})) * 64'($signed({sb, b}));
`endif
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      m_d     = m_q;
      div_d   = div_q;
      neg_d   = neg_q;
      sa_d    = sa_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         if (mthi_en) hi_d = a;
         if (mtlo_en) lo_d = a;
`ifdef MULDIV_FAST_MULT_EN
         if (start && !abort && !op[1]) begin
            hi_d   = fprod[63:32];
            lo_d   = fprod[31:0];
            done_d = 1'b1;
         end else
`endif
         if (start && !abort) begin
            state_d = RUN;
            cnt_d   = '0;
            acc_d   = {32'd0, op[1] ? abs_a : abs_b};
            m_d     = op[1] ? abs_b : abs_a;
            div_d   = op[1];
            neg_d   = sa ^ sb;
            sa_d    = sa;
            dz_d    = op[1] && b == '0;
         end
      end else if (abort) begin
         state_d = IDLE;
      end else if (state_q == RUN) begin
         acc_d   = step;
         cnt_d   = cnt_q + 6'd1;
         state_d = cnt_q == 6'd31 ? FIX : RUN;
      end else begin
         hi_d    = div_q ? rem : prod[63:32];
         lo_d    = div_q ? quo : prod[31:0];
         done_d  = 1'b1;
         state_d = IDLE;
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         m_q     <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         sa_q    <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         m_q     <= m_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         sa_q    <= sa_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end
   assign busy = state_q != IDLE;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;
   logic        clock = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
   logic        mthi_en = 1'b0, mtlo_en = 1'b0;
   logic [1:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic [31:0] hi, lo;
   logic        busy, done;

   ex_muldiv dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .abort(abort), .mthi_en(mthi_en), .mtlo_en(mtlo_en),
      .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct { logic [63:0] res; int t0; int lat; } exp_t;
   exp_t sb[$];
   exp_t m;
   int total = 0, bad = 0, cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, expv);
      end
   endtask

   // {HI, LO} straight from the architectural definition of each op
   function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx = longint'($signed(x));
      longint sy = longint'($signed(y));
      logic [63:0] ux = {32'd0, x};
      logic [63:0] uy = {32'd0, y};
      case (o)
         2'd0:    return 64'(sx * sy);
         2'd1:    return ux * uy;
         2'd2:    return (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
         default: return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      endcase
   endfunction

   function automatic int exp_lat(input logic [1:0] o);
`ifdef MULDIV_FAST_MULT_EN
      return o[1] ? 33 : 1;
`else
      return (o == o) ? 33 : 33;
`endif
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'd1;
         4:       return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   always @(negedge clock) begin
      if (done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done hi=%h lo=%h want no done", hi, lo);
         end else begin
            m = sb.pop_front();
            chk("hi", {32'd0, hi}, {32'd0, m.res[63:32]});
            chk("lo", {32'd0, lo}, {32'd0, m.res[31:0]});
            chk("latency", 64'(cyc - m.t0), 64'(m.lat));
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL idle_timeout busy=%b want 0", busy);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      e.res = ref_model(o, x, y);
      e.t0  = cyc + 1;
      e.lat = exp_lat(o);
      sb.push_back(e);
      op = o; a = x; b = y; start = 1'b1;
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit with_mtlo);
      int n = 0;
      wait_idle();
      issue(o, x, y);
      mtlo_en = with_mtlo;
      @(negedge clock);
      start = 1'b0;
      mtlo_en = 1'b0;
      if (with_mtlo) chk("mtlo_with_start", {32'd0, lo}, {32'd0, x});
      while (busy && n < 100) begin
         n++;
         @(negedge clock);
      end
      chk("busy_cycles", 64'(n), 64'(exp_lat(o) == 1 ? 0 : 33));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [31:0] hold_hi, hold_lo;
      repeat (3) @(negedge clock);
      chk("reset_hi", {32'd0, hi}, 64'd0);
      chk("reset_lo", {32'd0, lo}, 64'd0);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      reset = 1'b0;
      @(negedge clock);

      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(2'd3, 32'd100, 32'd7, 1'b0);
      run_op(2'd2, 32'h1234_5678, 32'd0, 1'b0);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(2'd3, 32'hDEAD_BEEF, 32'd3, 1'b1);

      wait_idle();
      mthi_en = 1'b1; a = 32'hAAAA_0000;
      @(negedge clock);
      mthi_en = 1'b0;
      chk("mthi", {32'd0, hi}, 64'h0000_0000_AAAA_0000);
      hold_lo = lo;
      op = 2'd3; a = 32'd5000; b = 32'd13; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_hi", {32'd0, hi}, 64'h0000_0000_AAAA_0000);
      chk("abort_lo", {32'd0, lo}, {32'd0, hold_lo});
      run_op(2'd3, 32'd77, 32'd5, 1'b0);

      wait_idle();
      hold_hi = hi; hold_lo = lo;
      op = 2'd1; a = 32'd9; b = 32'd9; start = 1'b1; abort = 1'b1;
      @(negedge clock);
      start = 1'b0; abort = 1'b0;
      chk("start_abort_busy", {63'd0, busy}, 64'd0);
      @(negedge clock);
      chk("start_abort_hi", {32'd0, hi}, {32'd0, hold_hi});
      chk("start_abort_lo", {32'd0, lo}, {32'd0, hold_lo});

      wait_idle();
      issue(2'd3, 32'hFFFF_0001, 32'd17);
      @(negedge clock);
      start = 1'b0;
      repeat (4) @(negedge clock);
      op = 2'd0; a = 32'd3; b = 32'd3; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_idle();

      op = 2'd3; a = 32'd999; b = 32'd4; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (19) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("midrun_reset_hi", {32'd0, hi}, 64'd0);
      chk("midrun_reset_lo", {32'd0, lo}, 64'd0);
      chk("midrun_reset_busy", {63'd0, busy}, 64'd0);
      chk("midrun_reset_done", {63'd0, done}, 64'd0);

      for (int i = 0; i < 40; i++) run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0);

      wait_idle();
      repeat (3) @(negedge clock);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
